// File: rtl/sw_alloc_dsb.sv
// sw_alloc_dsb: 5-port DSB router switch allocator.
// Per-output round-robin arbiter with a packet lock held until the TAIL flit transfers.
// Optional lock watchdog: define SW_ALLOC_WDT_EN.
module sw_alloc_dsb #(
  parameter int unsigned NPORT     = 5,
  parameter int unsigned WDT_LIMIT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT*NPORT-1:0] req_vec,
  input  logic [NPORT-1:0]       in_valid,
  input  logic [NPORT-1:0]       in_tail,
  input  logic [NPORT-1:0]       out_ready,
  output logic [3*NPORT-1:0]     grant_sel,
  output logic [NPORT-1:0]       grant_vld,
  output logic [NPORT-1:0]       in_rd,
  output logic [NPORT-1:0]       out_wr,
  output logic [NPORT-1:0]       wdt_err
);

  localparam int unsigned IDW = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e         state_q [NPORT];
  state_e         state_d [NPORT];
  logic [IDW-1:0] ptr_q   [NPORT];
  logic [IDW-1:0] ptr_d   [NPORT];
  logic [IDW-1:0] sel_q   [NPORT];
  logic [IDW-1:0] sel_d   [NPORT];
  logic [NPORT-1:0] xfer;

  // Transfer qualification for locked outputs; routes pops back to the owning input
  always_comb begin
    xfer  = '0;
    in_rd = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      if (state_q[o] == LOCKED && in_valid[sel_q[o]] && out_ready[o]) begin
        xfer[o]         = 1'b1;
        in_rd[sel_q[o]] = 1'b1;
      end
    end
    out_wr = xfer;
  end

  // Per-output arbitration and lock/release next state
  always_comb begin
    logic [NPORT-1:0] cand;
    logic             found;
    int unsigned      idx;
    for (int unsigned o = 0; o < NPORT; o++) begin
      state_d[o] = state_q[o];
      ptr_d[o]   = ptr_q[o];
      sel_d[o]   = sel_q[o];
      cand       = '0;
      found      = 1'b0;
      idx        = 0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        cand[i] = req_vec[5'(NPORT*i + o)];
      end
      if (state_q[o] == IDLE) begin
        // search starts just after the last winner so it gets lowest priority
        for (int unsigned k = 1; k <= NPORT; k++) begin
          idx = 32'(ptr_q[o]) + k;
          if (idx >= NPORT) idx = idx - NPORT;
          if (!found && cand[3'(idx)]) begin
            found      = 1'b1;
            sel_d[o]   = 3'(idx);
            state_d[o] = LOCKED;
          end
        end
      end else if (xfer[o] && in_tail[sel_q[o]]) begin
        state_d[o] = IDLE;
        ptr_d[o]   = sel_q[o];
      end
    end
  end

  // State, pointer and select registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned o = 0; o < NPORT; o++) begin
        state_q[o] <= IDLE;
        ptr_q[o]   <= 3'd4;
        sel_q[o]   <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NPORT; o++) begin
        state_q[o] <= state_d[o];
        ptr_q[o]   <= ptr_d[o];
        sel_q[o]   <= sel_d[o];
      end
    end
  end

  // Output packing
  always_comb begin
    grant_sel = '0;
    grant_vld = '0;
    for (int unsigned o = 0; o < NPORT; o++) begin
      grant_sel[3*o +: 3] = sel_q[o];
      grant_vld[o]        = (state_q[o] == LOCKED);
    end
  end

`ifdef SW_ALLOC_WDT_EN
  localparam int unsigned WDT_W = (WDT_LIMIT > 255) ? $clog2(WDT_LIMIT + 1) : 8;

  logic [WDT_W-1:0] cnt_q [NPORT];
  logic [WDT_W-1:0] cnt_d [NPORT];
  logic [NPORT-1:0] err_q;
  logic [NPORT-1:0] err_d;

  // Stall counters: cleared on transfer or idle, saturating; error flag is sticky
  always_comb begin
    err_d = err_q;
    for (int unsigned o = 0; o < NPORT; o++) begin
      cnt_d[o] = cnt_q[o];
      if (state_q[o] == IDLE || xfer[o]) begin
        cnt_d[o] = '0;
      end else begin
        if (cnt_q[o] != '1) cnt_d[o] = cnt_q[o] + 1'b1;
        if (cnt_d[o] >= WDT_LIMIT[WDT_W-1:0]) err_d[o] = 1'b1;
      end
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= '0;
      for (int unsigned o = 0; o < NPORT; o++) cnt_q[o] <= '0;
    end else begin
      err_q <= err_d;
      for (int unsigned o = 0; o < NPORT; o++) cnt_q[o] <= cnt_d[o];
    end
  end

  assign wdt_err = err_q;
`else
  assign wdt_err = '0;
`endif

endmodule

// File: tb/tb_sw_alloc_dsb.sv
// Directed bench for sw_alloc_dsb (WDT expectations follow SW_ALLOC_WDT_EN).
module tb_sw_alloc_dsb;

  logic        clk;
  logic        rst;
  logic [24:0] req_vec;
  logic [4:0]  in_valid;
  logic [4:0]  in_tail;
  logic [4:0]  out_ready;
  logic [14:0] grant_sel;
  logic [4:0]  grant_vld;
  logic [4:0]  in_rd;
  logic [4:0]  out_wr;
  logic [4:0]  wdt_err;

  int checks   = 0;
  int failures = 0;

`ifdef SW_ALLOC_WDT_EN
  localparam logic [4:0] WDT_EXP = 5'b00001;
`else
  localparam logic [4:0] WDT_EXP = 5'b00000;
`endif

  sw_alloc_dsb #(.NPORT(5), .WDT_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_vec   (req_vec),
    .in_valid  (in_valid),
    .in_tail   (in_tail),
    .out_ready (out_ready),
    .grant_sel (grant_sel),
    .grant_vld (grant_vld),
    .in_rd     (in_rd),
    .out_wr    (out_wr),
    .wdt_err   (wdt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each input's request must be one-hot or zero
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        assert ($countones(req_vec[5*i +: 5]) <= 1) else begin
          failures++;
          $error("FAIL req_onehot: input=%0d observed=%b expected=onehot", i, req_vec[5*i +: 5]);
        end
      end
    end
  end

  logic [2:0] rr_exp [6];

  initial begin
    rr_exp[0] = 3'd0; rr_exp[1] = 3'd2; rr_exp[2] = 3'd4;
    rr_exp[3] = 3'd0; rr_exp[4] = 3'd2; rr_exp[5] = 3'd4;

    rst = 1'b0; req_vec = '0; in_valid = '0; in_tail = '0; out_ready = '0;
    #1;
    chk("rst_vld", grant_vld, 0);
    chk("rst_sel", grant_sel, 0);
    chk("rst_rd",  in_rd, 0);
    chk("rst_wr",  out_wr, 0);
    chk("rst_wdt", wdt_err, 0);
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk("idle_vld", grant_vld, 0);

    // Single packet W->E: HEAD, BODY, TAIL
    req_vec = 25'h0; req_vec[8] = 1'b1; in_valid = 5'b00010; out_ready = '1;
    #1;
    chk("we_grant_cycle_rd", in_rd, 0);
    chk("we_grant_cycle_vld", grant_vld, 0);
    tick();
    req_vec = '0;
    chk("we_vld", grant_vld, 5'b01000);
    chk("we_sel", grant_sel[11:9], 1);
    for (int f = 0; f < 3; f++) begin
      if (f == 2) in_tail = 5'b00010;
      #1;
      chk("we_rd", in_rd, 5'b00010);
      chk("we_wr", out_wr, 5'b01000);
      tick();
    end
    in_valid = '0; in_tail = '0;
    #1;
    chk("we_release_vld", grant_vld, 0);
    chk("we_hold_sel", grant_sel[11:9], 1);
    chk("we_idle_rd", in_rd, 0);
    tick(); tick();
    chk("idle_after_release", grant_vld, 0);

    // Round robin on P: inputs 0, 2, 4 with single-flit packets
    req_vec[4] = 1'b1; req_vec[14] = 1'b1; req_vec[24] = 1'b1;
    in_valid = 5'b10101; in_tail = 5'b10101;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("rr_vld", grant_vld, 5'b10000);
      chk("rr_sel", grant_sel[14:12], rr_exp[n]);
      chk("rr_rd", in_rd, 32'(5'b00001 << rr_exp[n]));
      chk("rr_wr", out_wr, 5'b10000);
      tick();
      chk("rr_release", grant_vld, 0);
    end
    req_vec = '0; in_valid = '0; in_tail = '0;

    // Backpressure N->S
    req_vec[10] = 1'b1; in_valid = 5'b00100;
    tick();
    req_vec = '0;
    chk("bp_vld", grant_vld, 5'b00001);
    chk("bp_sel", grant_sel[2:0], 2);
    chk("bp_head_rd", in_rd, 5'b00100);
    chk("bp_head_wr", out_wr, 5'b00001);
    tick();
    out_ready = 5'b11110;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_stall_rd", in_rd, 0);
      chk("bp_stall_wr", out_wr, 0);
      chk("bp_stall_vld", grant_vld, 5'b00001);
      tick();
    end
    chk("bp_wdt", wdt_err, WDT_EXP);
    out_ready = '1;
    #1;
    chk("bp_body_rd", in_rd, 5'b00100);
    chk("bp_body_wr", out_wr, 5'b00001);
    tick();
    in_tail = 5'b00100;
    #1;
    chk("bp_tail_rd", in_rd, 5'b00100);
    chk("bp_locked_tail", grant_vld, 5'b00001);
    tick();
    in_valid = '0; in_tail = '0;
    chk("bp_release", grant_vld, 0);
    chk("bp_wdt_sticky", wdt_err, WDT_EXP);

    // Parallel: S->N, W->E, E->W, N->S, P->P
    req_vec[2] = 1'b1; req_vec[8] = 1'b1; req_vec[16] = 1'b1;
    req_vec[10] = 1'b1; req_vec[24] = 1'b1;
    in_valid = '1;
    tick();
    req_vec = '0;
    chk("par_vld", grant_vld, 5'b11111);
    chk("par_sel", grant_sel, {3'd4, 3'd1, 3'd0, 3'd3, 3'd2});
    chk("par_rd", in_rd, 5'b11111);
    chk("par_wr", out_wr, 5'b11111);
    tick();
    in_tail = '1;
    #1;
    chk("par_tail_wr", out_wr, 5'b11111);
    tick();
    in_valid = '0; in_tail = '0;
    chk("par_release", grant_vld, 0);

    // Reset mid-packet, then pointers restart at 4
    req_vec[8] = 1'b1; in_valid = 5'b00010;
    tick();
    req_vec = '0;
    chk("mid_rd", in_rd, 5'b00010);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_vld", grant_vld, 0);
    chk("mid_rst_rd", in_rd, 0);
    chk("mid_rst_wr", out_wr, 0);
    chk("mid_rst_sel", grant_sel, 0);
    chk("mid_rst_wdt", wdt_err, 0);
    tick();
    rst = 1'b1; in_valid = '0;
    tick();
    chk("post_rst_idle", grant_vld, 0);
    req_vec[3] = 1'b1; req_vec[13] = 1'b1;
    tick();
    req_vec = '0;
    chk("ptr_reset_vld", grant_vld, 5'b01000);
    chk("ptr_reset_sel", grant_sel[11:9], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_alloc_dsb.md
Name: sw_alloc_dsb

Overview:
Switch allocator for the 5-port DSB router.
- Consumes the per-input one-hot request vectors produced by the header decoders. Port order for inputs and outputs: S=0, W=1, N=2, E=3, P=4.
- Runs an independent round-robin arbiter per output port.
- Locks each output to its winning input until that packet's TAIL flit has crossed.
- Drives crossbar select, input-FIFO pop and output write strobes.

Parameters:
- NPORT, 5, number of router ports (fixed at 5; present for readability).
- WDT_LIMIT, 255, stall-cycle threshold for the lock watchdog (used only with SW_ALLOC_WDT_EN).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- req_vec  input  25  request vectors; bits [5i+4:5i] = one-hot request of input i (zero when FIFO head is not a HEAD)
- in_valid  input  5  input FIFO i non-empty
- in_tail  input  5  flit at head of input FIFO i is a TAIL
- out_ready  input  5  output o can accept a flit this cycle (downstream not full)
- grant_sel  output  15  bits [3o+2:3o] = input ID driving output o (crossbar select)
- grant_vld  output  5  output o is locked to grant_sel[o]
- in_rd  output  5  pop input FIFO i this cycle
- out_wr  output  5  write flit into output o this cycle
- wdt_err  output  5  sticky watchdog flag per output (tied 0 without SW_ALLOC_WDT_EN)

Behaviour:
- Reset (rst=0, async): every output to IDLE; grant_vld=0, grant_sel=0, wdt_err=0; all RR pointers=4, so input 0 has top priority first. in_rd/out_wr are 0 while rst=0. A packet in flight is abandoned; the arbiter restarts clean.
- Per-output FSM has two states, IDLE and LOCKED.
- IDLE, output o:
  - Candidate set = {i : req_vec[5i+o]=1}.
  - Winner = first candidate searching ptr[o]+1, ptr[o]+2, … modulo 5.
  - If the set is non-empty, on the next clk edge: state becomes LOCKED, grant_sel[o]=winner, grant_vld[o]=1.
  - No transfer occurs in the grant cycle. Request-to-grant latency is 1 cycle.
- LOCKED, output o with owner w:
  - transfer = in_valid[w] & out_ready[o]. It is combinational in the same cycle: in_rd[w]=transfer, out_wr[o]=transfer.
  - If transfer & in_tail[w]: next edge goes to IDLE, grant_vld[o]=0, ptr[o]=w (w gets lowest priority next round). grant_sel holds its last value.
  - Otherwise remain LOCKED; in_valid=0 or out_ready=0 stalls with no side effects.
- Each input requests at most one output (one-hot), so in_rd has at most one source per input. in_rd[i] = OR over o of (transfer_o & owner_o==i).
- Single-flit packet (HEAD with in_tail=1): lock, one transfer, release. Minimum 2 cycles per packet per output.
- Release and re-arbitration: an output releasing at edge N is IDLE in cycle N+1 and can grant at edge N+1. There is no same-cycle release-and-grant.
- Multiple outputs may lock and transfer in the same cycle, with no interaction between them.
- req_vec bits for an output already LOCKED are ignored until it returns to IDLE.
- A req_vec entry with more than one bit set is illegal; behaviour is undefined and the bench asserts against it.

Optional Feature:
SW_ALLOC_WDT_EN
- Defined: per output, an 8-bit-min stall counter.
  - Cleared on any transfer or in IDLE.
  - Increments each LOCKED cycle without a transfer, saturating.
  - When the count reaches WDT_LIMIT, wdt_err[o] sets and stays set until reset. It is diagnostic only; the lock is not broken.
- Not defined: no counters; wdt_err=5'b00000 constant.

Test Plan:
1. Reset/idle: rst=0 mid-packet → grant_vld=0, in_rd=0, out_wr=0 immediately. After release with req_vec=0: all outputs stay IDLE.
2. Single packet W→E:
   - Stimulus: req_vec[9:5]=5'b01000 at cycle 0; in_valid[1]=1; out_ready=all 1; flits HEAD, BODY, TAIL.
   - Required: grant_sel[11:9]=1 and grant_vld[3]=1 after edge 1; in_rd[1]=out_wr[3]=1 for 3 consecutive cycles; grant_vld[3]=0 after the TAIL edge.
3. Round-robin fairness: inputs 0, 2, 4 all request P continuously with single-flit packets → grant order 0, 2, 4, 0, 2, 4…, each granted exactly once per 3 packets.
4. Backpressure: locked N→S with out_ready[0]=0 for 5 cycles mid-packet → no in_rd/out_wr during stall; BODY and TAIL complete after out_ready returns; lock held throughout.
5. Parallel paths: S→N, W→E, E→W, N→S, P→P requested simultaneously → all five locked at the same edge; five concurrent out_wr per cycle.
6. With SW_ALLOC_WDT_EN and WDT_LIMIT=4: locked output with in_valid[w]=0 for 4 cycles → wdt_err[o]=1 and stays 1 after traffic resumes; without the macro wdt_err=0.
